// File: rtl/msdap_s2p_input.sv
// Serial-to-parallel front end for the MSDAP core: resynchronises dClk-framed L/R bit streams into sClk words.
// Optional zero-run sleep detection is built only when MSDAP_SLEEP_DETECT_EN is defined.
`timescale 1ns/1ps
module msdap_s2p_input #(
  parameter int WORD_W      = 16,
  parameter int RJ_COUNT    = 16,
  parameter int COEFF_COUNT = 512,
  parameter int SYNC_STAGES = 2,
  parameter int ZERO_RUN    = 800
) (
  input  logic              sClk,
  input  logic              reset,
  input  logic              dClk,
  input  logic              frame,
  input  logic              inDataL,
  input  logic              inDataR,
  output logic              inReady,
  output logic [WORD_W-1:0] wordL,
  output logic [WORD_W-1:0] wordR,
  output logic              word_valid,
  output logic [1:0]        word_kind,
  output logic [9:0]        word_index,
  output logic              frame_err,
  output logic              sleep
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [1:0] K_RJ = 2'b00, K_COEF = 2'b01, K_DATA = 2'b10;

  if (SYNC_STAGES < 2 || ZERO_RUN < 1) begin : g_bad_cfg
    $error("msdap_s2p_input: SYNC_STAGES must be >= 2 and ZERO_RUN >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT_FRAME, S_SHIFT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_dclk_sync, r_frame_sync, r_dl_sync, r_dr_sync;
  logic                   r_dclk_prev;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [WORD_W-2:0]      r_shl, r_shr;
  logic [WORD_W-1:0]      r_word_l, r_word_r;
  logic                   r_word_valid, r_frame_err;
  logic [1:0]             r_word_kind, r_seq_kind;
  logic [9:0]             r_word_index, r_seq_idx;

  logic w_dclk, w_frame, w_dl, w_dr, w_sample;
  logic w_start, w_shift, w_done, w_err;
  logic [WORD_W-1:0] w_word_l_nxt, w_word_r_nxt;

  assign w_dclk       = r_dclk_sync[SYNC_STAGES-1];
  assign w_frame      = r_frame_sync[SYNC_STAGES-1];
  assign w_dl         = r_dl_sync[SYNC_STAGES-1];
  assign w_dr         = r_dr_sync[SYNC_STAGES-1];
  // dClk falling edge lands mid-bit, where frame/data are settled
  assign w_sample     = r_dclk_prev & ~w_dclk;
  assign w_word_l_nxt = {r_shl, w_dl};
  assign w_word_r_nxt = {r_shr, w_dr};

  // Synchroniser stage
  always_ff @(posedge sClk) begin
    if (reset) begin
      r_dclk_sync  <= '0;
      r_frame_sync <= '0;
      r_dl_sync    <= '0;
      r_dr_sync    <= '0;
      r_dclk_prev  <= 1'b0;
    end else begin
      r_dclk_sync  <= {r_dclk_sync[SYNC_STAGES-2:0], dClk};
      r_frame_sync <= {r_frame_sync[SYNC_STAGES-2:0], frame};
      r_dl_sync    <= {r_dl_sync[SYNC_STAGES-2:0], inDataL};
      r_dr_sync    <= {r_dr_sync[SYNC_STAGES-2:0], inDataR};
      r_dclk_prev  <= w_dclk;
    end
  end

  always_ff @(posedge sClk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (w_sample && w_frame) begin
          w_start     = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_sample) begin
          if (r_bit_cnt == '0) begin
            if (w_frame) begin
              w_start = 1'b1;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = S_WAIT_FRAME;
            end
          end else if (w_frame) begin
            // early frame: drop the partial word, this bit is the new MSB
            w_err   = 1'b1;
            w_start = 1'b1;
          end else if (r_bit_cnt == LAST_BIT) begin
            w_done = 1'b1;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Assembly and output register stage
  always_ff @(posedge sClk) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_shl        <= '0;
      r_shr        <= '0;
      r_word_l     <= '0;
      r_word_r     <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_word_kind  <= K_RJ;
      r_word_index <= '0;
      r_seq_kind   <= K_RJ;
      r_seq_idx    <= '0;
    end else begin
      r_word_valid <= w_done;
      r_frame_err  <= w_err;
      if (w_start) begin
        r_shl     <= {{(WORD_W-2){1'b0}}, w_dl};
        r_shr     <= {{(WORD_W-2){1'b0}}, w_dr};
        r_bit_cnt <= CNT_W'(1);
      end else if (w_shift) begin
        r_shl     <= w_word_l_nxt[WORD_W-2:0];
        r_shr     <= w_word_r_nxt[WORD_W-2:0];
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else if (w_done) begin
        r_word_l     <= w_word_l_nxt;
        r_word_r     <= w_word_r_nxt;
        r_bit_cnt    <= '0;
        r_word_kind  <= r_seq_kind;
        r_word_index <= r_seq_idx;
        case (r_seq_kind)
          K_RJ: begin
            if (r_seq_idx == 10'(RJ_COUNT - 1)) begin
              r_seq_kind <= K_COEF;
              r_seq_idx  <= '0;
            end else begin
              r_seq_idx <= r_seq_idx + 1'b1;
            end
          end
          K_COEF: begin
            if (r_seq_idx == 10'(COEFF_COUNT - 1)) begin
              r_seq_kind <= K_DATA;
              r_seq_idx  <= '0;
            end else begin
              r_seq_idx <= r_seq_idx + 1'b1;
            end
          end
          default: r_seq_idx <= r_seq_idx + 1'b1;
        endcase
      end
    end
  end

  assign inReady    = (r_state != S_IDLE);
  assign wordL      = r_word_l;
  assign wordR      = r_word_r;
  assign word_valid = r_word_valid;
  assign word_kind  = r_word_kind;
  assign word_index = r_word_index;
  assign frame_err  = r_frame_err;

`ifdef MSDAP_SLEEP_DETECT_EN
  localparam int ZC_W = $clog2(ZERO_RUN + 1);

  logic [ZC_W-1:0] r_zero_cnt;
  logic            r_sleep;
  logic            w_zero_word;

  function automatic logic [ZC_W-1:0] sat_inc(input logic [ZC_W-1:0] v);
    return (v >= ZC_W'(ZERO_RUN)) ? v : v + 1'b1;
  endfunction

  assign w_zero_word = (w_word_l_nxt == '0) && (w_word_r_nxt == '0);

  // Zero-run stage, updated alongside the word registers
  always_ff @(posedge sClk) begin
    if (reset) begin
      r_zero_cnt <= '0;
      r_sleep    <= 1'b0;
    end else if (w_done && r_seq_kind == K_DATA) begin
      if (w_zero_word) begin
        r_zero_cnt <= sat_inc(r_zero_cnt);
        r_sleep    <= (sat_inc(r_zero_cnt) >= ZC_W'(ZERO_RUN));
      end else begin
        r_zero_cnt <= '0;
        r_sleep    <= 1'b0;
      end
    end
  end

  assign sleep = r_sleep;
`else
  assign sleep = 1'b0;
`endif

endmodule

// File: tb/tb_msdap_s2p_input.sv
// Scoreboard bench for msdap_s2p_input: expected words are queued as serial words are driven.
`timescale 1ns/1ps
module tb_msdap_s2p_input;

  localparam int RJ = 16, CF = 512, ZR = 800;

  logic        sClk = 1'b0, reset, dClk, frame, inDataL, inDataR;
  logic        inReady, word_valid, frame_err, sleep;
  logic [15:0] wordL, wordR;
  logic [1:0]  word_kind;
  logic [9:0]  word_index;

  typedef struct {
    logic [15:0] l, r;
    logic [1:0]  k;
    logic [9:0]  i;
    logic        s;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0, n_fail = 0;
  int   n_ferr = 0, exp_ferr = 0;
  int   m_n = 0, m_zc = 0;
  logic m_sleep = 1'b0;

  msdap_s2p_input dut (
    .sClk(sClk), .reset(reset), .dClk(dClk), .frame(frame),
    .inDataL(inDataL), .inDataR(inDataR), .inReady(inReady),
    .wordL(wordL), .wordR(wordR), .word_valid(word_valid),
    .word_kind(word_kind), .word_index(word_index),
    .frame_err(frame_err), .sleep(sleep)
  );

  always #19 sClk = ~sClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    e.l = l;
    e.r = r;
    if (m_n < RJ) begin
      e.k = 2'b00; e.i = 10'(m_n);
    end else if (m_n < RJ + CF) begin
      e.k = 2'b01; e.i = 10'(m_n - RJ);
    end else begin
      e.k = 2'b10; e.i = 10'((m_n - RJ - CF) % 1024);
`ifdef MSDAP_SLEEP_DETECT_EN
      if (l == 16'h0 && r == 16'h0) begin
        if (m_zc < ZR) m_zc++;
        m_sleep = (m_zc >= ZR);
      end else begin
        m_zc    = 0;
        m_sleep = 1'b0;
      end
`endif
    end
    e.s = m_sleep;
    q.push_back(e);
    m_n++;
  endtask

  // Drives the top nbits of a word, frame high on the first one.
  task automatic send_word(input logic [15:0] l, input logic [15:0] r, input int nbits, input int half);
    @(negedge sClk);
    if (half != 38) #1;
    for (int b = 0; b < nbits; b++) begin
      frame   = (b == 0);
      inDataL = l[15-b];
      inDataR = r[15-b];
      dClk    = 1'b1;
      #(half);
      dClk    = 1'b0;
      #(half);
    end
    frame = 1'b0;
  endtask

  task automatic send_stray(input int nbits);
    @(negedge sClk);
    for (int b = 0; b < nbits; b++) begin
      frame = 1'b0; inDataL = 1'b1; inDataR = 1'b1;
      dClk = 1'b1; #38;
      dClk = 1'b0; #38;
    end
  endtask

  task automatic send_rand();
    logic [15:0] l, r;
    l = 16'($urandom);
    r = 16'($urandom);
    push(l, r);
    send_word(l, r, 16, 38);
  endtask

  task automatic drain(input string tag);
    repeat (8) @(posedge sClk);
    #1;
    chk(tag, q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge sClk);
      #1;
      if (frame_err === 1'b1) n_ferr++;
      if (word_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_valid", q.size(), 1);
        end else begin
          mon_e = q.pop_front();
          chk("wordL", wordL, mon_e.l);
          chk("wordR", wordR, mon_e.r);
          chk("kind", word_kind, mon_e.k);
          chk("index", word_index, mon_e.i);
          chk("sleep", sleep, mon_e.s);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout pending=%0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; dClk = 1'b0; frame = 1'b0; inDataL = 1'b0; inDataR = 1'b0;
    repeat (3) @(posedge sClk);
    #1;
    chk("rst_inReady", inReady, 0);
    chk("rst_wordL", wordL, 0);
    chk("rst_wordR", wordR, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_kind", word_kind, 0);
    chk("rst_index", word_index, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_sleep", sleep, 0);
    @(negedge sClk) reset = 1'b0;
    repeat (2) @(posedge sClk);
    #1;
    chk("inReady", inReady, 1);

    // First Rj word at the slow dClk rate
    push(16'h0012, 16'h0034);
    send_word(16'h0012, 16'h0034, 16, 651);
    drain("drain_first");

    // Early frame at bit 7: the erroneous bit starts the next word
    send_word(16'hFFFF, 16'h0000, 7, 38);
    exp_ferr++;
    push(16'hA5C3, 16'h3C5A);
    send_word(16'hA5C3, 16'h3C5A, 16, 38);
    drain("drain_ferr");
    chk("ferr_mid", n_ferr, exp_ferr);

    // Missing frame after a completed word, then ignored bits in WAIT_FRAME
    send_stray(3);
    exp_ferr++;
    push(16'h1357, 16'h2468);
    send_word(16'h1357, 16'h2468, 16, 38);
    drain("drain_gap");
    chk("ferr_gap", n_ferr, exp_ferr);

    // Reset at bit 9 of coefficient 100
    while (m_n < RJ + 100) send_rand();
    send_word(16'hBEEF, 16'hCAFE, 9, 38);
    @(negedge sClk) reset = 1'b1;
    m_n = 0; m_zc = 0; m_sleep = 1'b0;
    repeat (3) @(posedge sClk);
    #1;
    chk("rst_drop", q.size(), 0);
    chk("rst2_wordL", wordL, 0);
    chk("rst2_index", word_index, 0);
    chk("rst2_ferr_cnt", n_ferr, exp_ferr);
    @(negedge sClk) reset = 1'b0;

    // Full Rj + coefficient load, then data words
    while (m_n < RJ + CF) send_rand();
    drain("drain_coef");
    chk("last_coef_idx", word_index, 511);
    push(16'h8000, 16'h7FFF); send_word(16'h8000, 16'h7FFF, 16, 38);
    push(16'h1234, 16'hFEDC); send_word(16'h1234, 16'hFEDC, 16, 38);
    push(16'h0F0F, 16'hF0F0); send_word(16'h0F0F, 16'hF0F0, 16, 38);
    for (int z = 0; z < ZR; z++) begin
      push(16'h0000, 16'h0000);
      send_word(16'h0000, 16'h0000, 16, 38);
    end
    drain("drain_zero");
`ifdef MSDAP_SLEEP_DETECT_EN
    chk("sleep_hi", sleep, 1);
`else
    chk("sleep_off", sleep, 0);
`endif
    push(16'h0001, 16'h0000);
    send_word(16'h0001, 16'h0000, 16, 38);
    drain("drain_wake");
    chk("sleep_lo", sleep, 0);
    while (m_n < RJ + CF + 1025) begin
      logic [15:0] l, r;
      l = 16'($urandom) | 16'h1;
      r = 16'($urandom);
      push(l, r);
      send_word(l, r, 16, 38);
    end
    drain("drain_wrap");
    chk("wrap_kind", word_kind, 2);
    chk("wrap_idx", word_index, 0);
    chk("ferr_total", n_ferr, exp_ferr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
